// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: the memory read port toward the cache and the instruction port toward the IR stage.
// Handshakes: a read is issued while mem_read=1 and completes on the one-cycle mem_resp pulse;
// the instruction transfers on any rising edge where instr_valid=1 and instr_ready=1.
interface instr_fetch_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_address, mem_read, instr, instr_pc, instr_valid,
        input  mem_rdata, mem_resp, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_address, mem_read, instr, instr_pc, instr_valid,
        output mem_rdata, mem_resp, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-entry instruction fetch unit: one outstanding read, one buffered instruction,
// with redirects that squash in-flight reads by draining them.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     bus,
    output logic [1:0]        state_dbg
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;
    logic [15:0] req_addr;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc;
    logic [15:0] redir_tgt;

    // Instruction addresses are halfword aligned.
    assign redir_tgt = {bus.redirect_pc[15:1], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= 16'h0000;
            buf_pc    <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.redirect) begin
                        pc <= redir_tgt;
                        if (bus.mem_resp) begin
                            req_addr <= redir_tgt;
                            state    <= FETCH;
                        end else begin
                            // Read already issued at req_addr must finish before retargeting.
                            state <= DRAIN;
                        end
                    end else if (bus.mem_resp) begin
                        buf_instr <= bus.mem_rdata;
                        buf_pc    <= req_addr;
                        pc        <= req_addr + 16'd2;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        req_addr <= redir_tgt;
                        pc       <= redir_tgt;
                        state    <= FETCH;
                    end else if (bus.instr_ready) begin
                        req_addr <= pc;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.mem_resp) begin
                        req_addr <= bus.redirect ? redir_tgt : pc;
                        pc       <= bus.redirect ? redir_tgt : pc;
                        state    <= FETCH;
                    end else if (bus.redirect) begin
                        pc <= redir_tgt;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Reset leaves state at FETCH, so mem_read is gated to stay low while reset is held.
    assign bus.mem_read    = !reset && (state != HOLD);
    assign bus.mem_address = req_addr;
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = buf_instr;
    assign bus.instr_pc    = buf_pc;
    assign state_dbg       = state;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus hand-written hold and reset sequences.
module tb_instr_fetch;
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic clk;
  logic reset;
  logic [1:0] state_dbg;
  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        redir;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        ready;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [15:0] rpc, input logic resp,
                       input logic [15:0] rdata, input logic ready);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.mem_resp    = resp;
    bus.mem_rdata   = rdata;
    bus.instr_ready = ready;
  endtask

  task automatic chk_out(input string tag, input logic rd, input logic [15:0] addr,
                         input logic val, input logic [15:0] ins, input logic [15:0] ipc,
                         input logic [1:0] st);
    chk({tag, "_mem_read"}, {15'd0, bus.mem_read}, {15'd0, rd});
    chk({tag, "_mem_address"}, bus.mem_address, addr);
    chk({tag, "_instr_valid"}, {15'd0, bus.instr_valid}, {15'd0, val});
    chk({tag, "_instr"}, bus.instr, ins);
    chk({tag, "_instr_pc"}, bus.instr_pc, ipc);
    chk({tag, "_state"}, {14'd0, state_dbg}, {14'd0, st});
  endtask

  function automatic vec_t mk(input logic redir, input logic [15:0] rpc, input logic resp,
                              input logic [15:0] rdata, input logic ready, input logic e_rd,
                              input logic [15:0] e_addr, input logic e_val,
                              input logic [15:0] e_instr, input logic [15:0] e_ipc,
                              input logic [1:0] e_state);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.resp = resp; v.rdata = rdata; v.ready = ready;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_val = e_val; v.e_instr = e_instr;
    v.e_ipc = e_ipc; v.e_state = e_state;
    return v;
  endfunction

  initial begin
    total = 0;
    bad = 0;
    // Each entry: expected outputs seen before an edge, then the inputs applied for that edge.
    //              redir rpc       resp rdata     rdy  rd   addr      val  instr     ipc       state
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h1234, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1234, 16'h0000, S_HOLD));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h5678, 0, 1, 16'h0002, 0, 16'h1234, 16'h0000, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h5678, 16'h0002, S_HOLD));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h5678, 16'h0002, S_HOLD));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0002, 1, 16'h5678, 16'h0002, S_HOLD));
    // redirect to 3001 while 0004 is pending: drain, drop data, refetch at 3000
    vecs.push_back(mk(1, 16'h3001, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h5678, 16'h0002, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h5678, 16'h0002, S_DRAIN));
    vecs.push_back(mk(0, 16'h0000, 1, 16'hDEAD, 0, 1, 16'h0004, 0, 16'h5678, 16'h0002, S_DRAIN));
    // redirect and mem_resp together in FETCH
    vecs.push_back(mk(1, 16'h4000, 1, 16'hBEEF, 0, 1, 16'h3000, 0, 16'h5678, 16'h0002, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 1, 16'hAAAA, 0, 1, 16'h4000, 0, 16'h5678, 16'h0002, S_FETCH));
    // redirect in HOLD with ready=1: delivered, then fetch at FFFE
    vecs.push_back(mk(1, 16'hFFFF, 0, 16'h0000, 1, 0, 16'h4000, 1, 16'hAAAA, 16'h4000, S_HOLD));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h1111, 0, 1, 16'hFFFE, 0, 16'hAAAA, 16'h4000, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'hFFFE, 1, 16'h1111, 16'hFFFE, S_HOLD));
    vecs.push_back(mk(1, 16'h2000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h1111, 16'hFFFE, S_FETCH));
    vecs.push_back(mk(1, 16'h2222, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h1111, 16'hFFFE, S_DRAIN));
    vecs.push_back(mk(1, 16'h2469, 1, 16'h6666, 0, 1, 16'h0000, 0, 16'h1111, 16'hFFFE, S_DRAIN));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h7777, 0, 1, 16'h2468, 0, 16'h1111, 16'hFFFE, S_FETCH));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h2468, 1, 16'h7777, 16'h2468, S_HOLD));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h246A, 0, 16'h7777, 16'h2468, S_FETCH));
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h7777);

    drive(0, 16'h0000, 0, 16'h0000, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_out("in_reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk_out($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_val,
              vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_state);
      if (bus.instr_valid && vecs[i].ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL v%0d_delivery actual=%h expected=none", i, bus.instr);
        end else begin
          chk($sformatf("v%0d_delivered", i), bus.instr, exp_q.pop_front());
        end
      end
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].resp, vecs[i].rdata, vecs[i].ready);
    end

    // hold with instr_ready low for 10 cycles
    @(negedge clk);
    drive(0, 16'h0000, 1, 16'h9999, 0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    for (int k = 0; k < 10; k++) begin
      chk_out($sformatf("hold%0d", k), 0, 16'h246A, 1, 16'h9999, 16'h246A, S_HOLD);
      @(negedge clk);
    end
    drive(0, 16'h0000, 0, 16'h0000, 1);
    @(negedge clk);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    chk_out("after_hold", 1, 16'h246C, 0, 16'h9999, 16'h246A, S_FETCH);

    // asynchronous reset while holding a valid instruction
    drive(0, 16'h0000, 1, 16'h5555, 0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    chk_out("pre_reset_hold", 0, 16'h246C, 1, 16'h5555, 16'h246C, S_HOLD);
    #2 reset = 1'b1;
    #1 chk_out("async_reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 16'h0000, 1, 16'hABCD, 0);
    #1 chk_out("post_reset", 1, 16'h0000, 0, 16'h0000, 16'h0000, S_FETCH);
    @(negedge clk);
    drive(0, 16'h0000, 0, 16'h0000, 1);
    chk_out("early_resp", 0, 16'h0000, 1, 16'hABCD, 16'h0000, S_HOLD);
    @(negedge clk);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    chk_out("resume", 1, 16'h0002, 0, 16'hABCD, 16'h0000, S_FETCH);

    chk("exp_q_left", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
